// File: rtl/rf_dump_serializer_pkg.sv
// Shared definitions for the register-file dump path: default geometry of the
// 4x16 CPU register file and the serializer state encoding.
package rf_dump_serializer_pkg;

  localparam int NUM_REGS_DEF   = 4;
  localparam int WORD_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } dump_state_e;

endpackage

// File: rtl/rf_dump_serializer_piso.sv
// Parallel-load / serial-out shift register; the MSB is the bit on the wire.
// Load wins over shift so a word capture is never corrupted by a stray enable.
module piso_shift16
  import rf_dump_serializer_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift_en,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
    end else if (i_shift_en) begin
      r_shift <= {r_shift[WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb = r_shift[WIDTH-1];

endmodule

// File: rtl/rf_dump_serializer.sv
// Walks the register-file read port through every register, snapshots each
// word and streams it MSB-first over a bit-serial valid/ready interface.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | rf_addr = index, word captured into the shift register at the edge
// SHIFT | presenting bits; advance on out_valid && out_ready
// DONE  | one-cycle done pulse, then back to IDLE
module rf_dump_serializer
  import rf_dump_serializer_pkg::*;
#(
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [WORD_WIDTH-1:0] rf_data,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_bit,
  output logic                  out_word_last,
  output logic                  out_frame_last
);

  localparam int BIT_W = $clog2(WORD_WIDTH);
  localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(WORD_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);

  dump_state_e           r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_index, w_index_nxt;
  logic [BIT_W-1:0]      r_bitcnt, w_bitcnt_nxt;
  logic                  w_load;
  logic                  w_shift;
  logic                  w_msb;
  logic                  w_word_end;
  logic                  w_last_reg;

  assign w_word_end = (r_bitcnt == LAST_BIT);
  assign w_last_reg = (r_index == LAST_REG);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_index  <= '0;
      r_bitcnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_index  <= w_index_nxt;
      r_bitcnt <= w_bitcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_index_nxt  = r_index;
    w_bitcnt_nxt = r_bitcnt;
    w_load       = 1'b0;
    w_shift      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = LOAD;
          w_index_nxt = '0;
        end
      end
      LOAD: begin
        w_load       = 1'b1;
        w_bitcnt_nxt = '0;
        w_state_nxt  = SHIFT;
      end
      SHIFT: begin
        if (out_ready) begin
          w_shift      = 1'b1;
          w_bitcnt_nxt = r_bitcnt + 1'b1;
          if (w_word_end) begin
            if (w_last_reg) begin
              w_state_nxt = DONE;
            end else begin
              w_index_nxt = r_index + 1'b1;
              w_state_nxt = LOAD;
            end
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_index_nxt = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_index_nxt = '0;
      end
    endcase

    // Abort overrides everything outside IDLE, including a final handshake;
    // the sink may still see that bit accepted but we drop it internally.
    if (abort && (r_state != IDLE)) begin
      w_state_nxt  = IDLE;
      w_index_nxt  = '0;
      w_bitcnt_nxt = r_bitcnt;
      w_load       = 1'b0;
      w_shift      = 1'b0;
    end
  end

  piso_shift16 #(
    .WIDTH(WORD_WIDTH)
  ) u_piso (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_load    (w_load),
    .i_shift_en(w_shift),
    .i_data    (rf_data),
    .o_msb     (w_msb)
  );

  assign rf_addr        = r_index;
  assign busy           = (r_state != IDLE);
  assign done           = (r_state == DONE);
  assign out_valid      = (r_state == SHIFT);
  assign out_bit        = w_msb;
  assign out_word_last  = out_valid && w_word_end;
  assign out_frame_last = out_word_last && w_last_reg;

endmodule
